// File: rtl/gpr_wb_arbiter_if.sv
// Writeback bus between the pipe/async producers and the GPR writeback arbiter.
// WB_ARB_PERF_EN adds the two performance counter outputs.
interface gpr_wb_arbiter_if #(
   parameter int N_ASYNC = 2
);
   logic                   p0_we_i;
   logic [4:0]             p0_num_i;
   logic [31:0]            p0_data_i;
   logic                   p1_we_i;
   logic [4:0]             p1_num_i;
   logic [31:0]            p1_data_i;
   logic [N_ASYNC-1:0]     as_valid_i;
   logic [5*N_ASYNC-1:0]   as_num_i;
   logic [32*N_ASYNC-1:0]  as_data_i;
   logic [N_ASYNC-1:0]     as_ready_o;
   logic                   stall_req_o;
   logic                   port0_we_o;
   logic [4:0]             port0_num_o;
   logic [31:0]            port0_data_o;
   logic                   port1_we_o;
   logic [4:0]             port1_num_o;
   logic [31:0]            port1_data_o;
`ifdef WB_ARB_PERF_EN
   logic [31:0]            perf_conflict_cnt_o;
   logic [31:0]            perf_stall_cnt_o;

   modport master (
      output p0_we_i, p0_num_i, p0_data_i, p1_we_i, p1_num_i, p1_data_i,
             as_valid_i, as_num_i, as_data_i,
      input  as_ready_o, stall_req_o, port0_we_o, port0_num_o, port0_data_o,
             port1_we_o, port1_num_o, port1_data_o,
             perf_conflict_cnt_o, perf_stall_cnt_o
   );
   modport slave (
      input  p0_we_i, p0_num_i, p0_data_i, p1_we_i, p1_num_i, p1_data_i,
             as_valid_i, as_num_i, as_data_i,
      output as_ready_o, stall_req_o, port0_we_o, port0_num_o, port0_data_o,
             port1_we_o, port1_num_o, port1_data_o,
             perf_conflict_cnt_o, perf_stall_cnt_o
   );
`else
   modport master (
      output p0_we_i, p0_num_i, p0_data_i, p1_we_i, p1_num_i, p1_data_i,
             as_valid_i, as_num_i, as_data_i,
      input  as_ready_o, stall_req_o, port0_we_o, port0_num_o, port0_data_o,
             port1_we_o, port1_num_o, port1_data_o
   );
   modport slave (
      input  p0_we_i, p0_num_i, p0_data_i, p1_we_i, p1_num_i, p1_data_i,
             as_valid_i, as_num_i, as_data_i,
      output as_ready_o, stall_req_o, port0_we_o, port0_num_o, port0_data_o,
             port1_we_o, port1_num_o, port1_data_o
   );
`endif
endinterface

// File: rtl/gpr_wb_arbiter.sv
// Packs pipe and async GPR writebacks onto the two regfile write ports, with a
// round-robin async grant and a starvation stall request. WB_ARB_PERF_EN adds perf counters.
module gpr_wb_arbiter #(
   parameter int N_ASYNC      = 2,
   parameter int STARVE_LIMIT = 8,
   parameter int CNT_W        = 4
) (
   input  logic                clk,
   input  logic                rst,
   gpr_wb_arbiter_if.slave     bus
);
   localparam int RR_W = (N_ASYNC > 1) ? $clog2(N_ASYNC) : 1;

   typedef enum logic {NORMAL, STALL} state_e;

   state_e             state;
   logic [RR_W-1:0]    rr_ptr;
   logic [RR_W-1:0]    rr_next;
   logic [CNT_W-1:0]   wait_cnt;
   logic [N_ASYNC-1:0] grant;
   logic [N_ASYNC-1:0] discard;
   logic               eff0, eff1, any_valid, any_grant;
   logic               nx_we0, nx_we1;
   logic [4:0]         nx_num0, nx_num1;
   logic [31:0]        nx_data0, nx_data1;

   // GPR 0 writes never reach the regfile and never occupy a port.
   assign eff0      = bus.p0_we_i && (bus.p0_num_i != 5'd0);
   assign eff1      = bus.p1_we_i && (bus.p1_num_i != 5'd0);
   assign any_valid = |bus.as_valid_i;
   assign any_grant = |grant;
   assign bus.as_ready_o = rst ? (grant | discard) : '0;

   always_comb begin
      int slots;
      int used;
      int k;
      // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
      grant    = '0;
      discard  = '0;
      rr_next  = rr_ptr;
      nx_we0   = 1'b0;
      nx_num0  = 5'd0;
      nx_data0 = 32'd0;
      nx_we1   = 1'b0;
      nx_num1  = 5'd0;
      nx_data1 = 32'd0;
      slots    = 2 - int'(eff0) - int'(eff1);
      used     = 0;
      k        = 0;
      // Async writes are oldest, so they take the ports first in scan order.
      for (int i = 0; i < N_ASYNC; i++) begin
         k = (int'(rr_ptr) + i) % N_ASYNC;
         if (bus.as_valid_i[k]) begin
            if (bus.as_num_i[5*k +: 5] == 5'd0) begin
               discard[k] = 1'b1;
            end else if (used < slots) begin
               grant[k] = 1'b1;
               rr_next  = RR_W'((k + 1) % N_ASYNC);
               if (used == 0) begin
                  nx_we0   = 1'b1;
                  nx_num0  = bus.as_num_i[5*k +: 5];
                  nx_data0 = bus.as_data_i[32*k +: 32];
               end else begin
                  nx_we1   = 1'b1;
                  nx_num1  = bus.as_num_i[5*k +: 5];
                  nx_data1 = bus.as_data_i[32*k +: 32];
               end
               used = used + 1;
            end
         end
      end
      if (eff0) begin
         if (used == 0) begin
            nx_we0   = 1'b1;
            nx_num0  = bus.p0_num_i;
            nx_data0 = bus.p0_data_i;
         end else begin
            nx_we1   = 1'b1;
            nx_num1  = bus.p0_num_i;
            nx_data1 = bus.p0_data_i;
         end
         used = used + 1;
      end
      if (eff1) begin
         if (used == 0) begin
            nx_we0   = 1'b1;
            nx_num0  = bus.p1_num_i;
            nx_data0 = bus.p1_data_i;
         end else begin
            nx_we1   = 1'b1;
            nx_num1  = bus.p1_num_i;
            nx_data1 = bus.p1_data_i;
         end
      end
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state            <= NORMAL;
         rr_ptr           <= '0;
         wait_cnt         <= '0;
         bus.stall_req_o  <= 1'b0;
         bus.port0_we_o   <= 1'b0;
         bus.port0_num_o  <= 5'd0;
         bus.port0_data_o <= 32'd0;
         bus.port1_we_o   <= 1'b0;
         bus.port1_num_o  <= 5'd0;
         bus.port1_data_o <= 32'd0;
`ifdef WB_ARB_PERF_EN
         bus.perf_conflict_cnt_o <= 32'd0;
         bus.perf_stall_cnt_o    <= 32'd0;
`endif
      end else begin
         bus.port0_we_o   <= nx_we0;
         bus.port0_num_o  <= nx_num0;
         bus.port0_data_o <= nx_data0;
         bus.port1_we_o   <= nx_we1;
         bus.port1_num_o  <= nx_num1;
         bus.port1_data_o <= nx_data1;
         rr_ptr           <= rr_next;
         // Counts consecutive denied cycles; a quiet cycle breaks the run.
         if (any_grant || !any_valid) begin
            wait_cnt <= '0;
         end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
         case (state)
            NORMAL: begin
               if (any_valid && !any_grant && wait_cnt == CNT_W'(STARVE_LIMIT - 1)) begin
                  state           <= STALL;
                  bus.stall_req_o <= 1'b1;
               end
            end
            STALL: begin
               if (any_grant || !any_valid) begin
                  state           <= NORMAL;
                  bus.stall_req_o <= 1'b0;
               end
            end
            default: begin
               state           <= NORMAL;
               bus.stall_req_o <= 1'b0;
            end
         endcase
`ifdef WB_ARB_PERF_EN
         if (any_valid && !any_grant) bus.perf_conflict_cnt_o <= bus.perf_conflict_cnt_o + 32'd1;
         if (bus.stall_req_o)         bus.perf_stall_cnt_o    <= bus.perf_stall_cnt_o + 32'd1;
`endif
      end
   end
endmodule
